// File: rtl/slice_buf_pkg.sv
// slice_buf_pkg: shared widths, depth and FILL/DRAIN state encoding for slice_buffer
package slice_buf_pkg;
  localparam int LINE_W = 25;
  localparam int DEPTH = 64;
  localparam int ADDR_W = 6;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;
endpackage

// File: rtl/buf_ptr_counter.sv
// buf_ptr_counter: ADDR_W-bit wrapping pointer (clk, rst, clr, en -> cnt, carry when en at DEPTH-1)
module buf_ptr_counter
  import slice_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              carry
);
  assign carry = en & (cnt == ADDR_W'(DEPTH - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/slice_buffer.sv
// slice_buffer: fill 64x25 frame buffer then drain in slice order over valid/ready (optional frame_xor via SLICE_BUF_FRAME_XOR_EN)
module slice_buffer
  import slice_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [LINE_W-1:0] in_line,
  output logic              in_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_line,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy
`ifdef SLICE_BUF_FRAME_XOR_EN
  ,
  output logic [LINE_W-1:0] frame_xor
`endif
);
  state_t st, st_nxt;
  logic [LINE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_carry, rd_carry, accept, transfer;
  assign in_ready = (st == FILL);
  assign out_valid = (st == DRAIN);
  assign busy = (st == DRAIN);
  assign accept = in_valid & in_ready;
  assign transfer = out_valid & out_ready;
  assign out_line = mem[rd_ptr];
  assign out_addr = rd_ptr;
  buf_ptr_counter u_wr (.clk(clk), .rst(rst), .clr(flush), .en(accept), .cnt(wr_ptr), .carry(wr_carry));
  buf_ptr_counter u_rd (.clk(clk), .rst(rst), .clr(flush), .en(transfer), .cnt(rd_ptr), .carry(rd_carry));
  always_comb st_nxt = flush ? FILL : (st == FILL) ? (wr_carry ? DRAIN : FILL) : (rd_carry ? FILL : DRAIN);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= FILL;
      frame_done <= 1'b0;
    end else begin
      st <= st_nxt;
      frame_done <= rd_carry & ~flush;
    end
  always_ff @(posedge clk)
    if (accept & ~flush) mem[wr_ptr] <= in_line;
`ifdef SLICE_BUF_FRAME_XOR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_xor <= '0;
    else if (flush) frame_xor <= '0;
    else if (accept) frame_xor <= (wr_ptr == '0 ? '0 : frame_xor) ^ in_line;
`endif
endmodule

// File: tb/tb_slice_buffer.sv
// tb_slice_buffer: randomized self-checking bench for slice_buffer against a queue-based frame model
module tb_slice_buffer;
  import slice_buf_pkg::*;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LINE_W-1:0] in_line = '0;
  logic in_ready, out_valid, frame_done, busy;
  logic [LINE_W-1:0] out_line;
  logic [ADDR_W-1:0] out_addr;
`ifdef SLICE_BUF_FRAME_XOR_EN
  logic [LINE_W-1:0] frame_xor;
`endif
  int vectors = 0, miscompares = 0;
  bit draining = 0, done_exp = 0;
  int rd = 0;
  logic [LINE_W-1:0] q[$];
  logic [LINE_W-1:0] xor_exp = '0;
  slice_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_line(in_line),
    .in_ready(in_ready), .out_valid(out_valid), .out_line(out_line), .out_addr(out_addr),
    .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
`ifdef SLICE_BUF_FRAME_XOR_EN
    , .frame_xor(frame_xor)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_outs();
    chk("in_ready", 32'(in_ready), 32'(!draining));
    chk("out_valid", 32'(out_valid), 32'(draining));
    chk("busy", 32'(busy), 32'(draining));
    chk("frame_done", 32'(frame_done), 32'(done_exp));
    if (draining) begin
      chk("out_addr", 32'(out_addr), 32'(rd));
      chk("out_line", 32'(out_line), 32'(q[rd]));
    end
`ifdef SLICE_BUF_FRAME_XOR_EN
    chk("frame_xor", 32'(frame_xor), 32'(xor_exp));
`endif
  endtask
  task automatic step(bit v, logic [LINE_W-1:0] line, bit ordy, bit fl);
    in_valid = v;
    in_line = line;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    done_exp = 0;
    if (fl) begin
      q.delete();
      draining = 0;
      rd = 0;
      xor_exp = '0;
    end else if (!draining) begin
      if (v) begin
        if (q.size() == 0) xor_exp = '0;
        q.push_back(line);
        xor_exp ^= line;
        if (q.size() == DEPTH) draining = 1;
      end
    end else if (ordy) begin
      rd++;
      if (rd == DEPTH) begin
        draining = 0;
        rd = 0;
        q.delete();
        done_exp = 1;
      end
    end
    #1;
    check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    q.delete();
    draining = 0;
    rd = 0;
    done_exp = 0;
    xor_exp = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_outs();
  endtask
  task automatic fill(int mode);
    int n = 0;
    while (!draining && n < 1000) begin
      int k = q.size();
      logic [LINE_W-1:0] l = (mode == 0) ? LINE_W'(k) : (mode == 2) ? (LINE_W'(1) << (k % LINE_W)) : LINE_W'($urandom);
      step((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1, l, 1'b1, 1'b0);
      n++;
    end
    if (!draining) chk("fill_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain(int stall_at, int stop_at, bit rnd);
    int n = 0, s = 0;
    while (draining && rd != stop_at && n < 1000) begin
      bit stall = (rd == stall_at && s < 5);
      if (stall) s++;
      step(1'b1, 25'h1FFFFFF, stall ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    do_reset();
    fill(0);
    drain(-1, -1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    fill(1);
    drain(10, -1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, LINE_W'($urandom), 1'b1, 1'b0);
    step(1'b1, LINE_W'($urandom), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    fill(1);
    drain(-1, -1, 1'b1);
    fill(1);
    drain(-1, 40, 1'b0);
    do_reset();
    fill(2);
    drain(-1, -1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, LINE_W'(1) << i, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
